// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM state type for the SPI shift engine
package spi_pkg;

    localparam int  MAX_WORD_LEN_DEFAULT = 16;
    localparam logic BIT_ORDER_MSB = 1'b0;
    localparam logic BIT_ORDER_LSB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - per-transfer bit counter with terminal matches against latched length
module spi_bit_counter #(
    parameter int LenW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic [LenW-1:0] len,
    output logic            at_term,
    output logic            at_last
);

    localparam logic [LenW-1:0] CNT_ONE = LenW'(1);

    logic [LenW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // at_last lets the FSM leave SHIFT on the same edge the final sample lands
    assign at_term = (cnt == len);
    assign at_last = ((cnt + CNT_ONE) == len);

endmodule

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - full-duplex SPI shift datapath; optional SPI_SHIFT_LOOPBACK_EN adds LoopBack
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int MaxWordLen = MAX_WORD_LEN_DEFAULT,
    parameter int LenW       = $clog2(MaxWordLen + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  logic                  LoopBack,
`endif
    input  logic                  Start,
    input  logic [MaxWordLen-1:0] DataIN,
    input  logic [LenW-1:0]       WordLenSel,
    input  logic                  BitOrder,
    input  logic                  ShiftEdgeFlg,
    input  logic                  SampleEdgeFlg,
    input  logic                  MISO,
    output logic                  MOSI,
    output logic                  Busy,
    output logic                  Done,
    output logic [MaxWordLen-1:0] RXData,
    output logic                  RXValid,
    input  logic                  RXAck,
    output logic                  Overrun
);

    localparam logic [LenW-1:0]       LEN_MAX = LenW'(MaxWordLen);
    localparam logic [LenW-1:0]       LEN_ONE = LenW'(1);
    localparam logic [MaxWordLen-1:0] ONE_W   = MaxWordLen'(1);

    spi_state_e            state;
    logic [MaxWordLen-1:0] tx_q;
    logic [MaxWordLen-1:0] rx_q;
    logic [LenW-1:0]       len_q;
    logic                  order_q;
    logic [LenW-1:0]       len_sel;
    logic                  mosi_int;
    logic                  rx_in;
    logic                  sample_en;
    logic                  shift_en;
    logic                  at_term;
    logic                  at_last;
    logic                  lb_active;

    assign len_sel = ((WordLenSel == '0) || (WordLenSel > LEN_MAX)) ? LEN_MAX : WordLenSel;

    // MSB-first words are left-aligned at load so the live bit is always tx_q[MSB]
    assign mosi_int  = (order_q == BIT_ORDER_MSB) ? tx_q[MaxWordLen-1] : tx_q[0];
    assign sample_en = (state == SHIFT) && SampleEdgeFlg && !at_term;
    assign shift_en  = (state == SHIFT) && ShiftEdgeFlg && !at_term;

`ifdef SPI_SHIFT_LOOPBACK_EN
    logic lb_q;
    assign lb_active = lb_q;
    assign rx_in     = lb_q ? mosi_int : MISO;
`else
    assign lb_active = 1'b0;
    assign rx_in     = MISO;
`endif

    assign MOSI = (state == SHIFT) && !lb_active && mosi_int;

    spi_bit_counter #(
        .LenW(LenW)
    ) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state == IDLE) && Start),
        .inc     (sample_en),
        .len     (len_q),
        .at_term (at_term),
        .at_last (at_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            len_q   <= LEN_MAX;
            order_q <= BIT_ORDER_MSB;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            RXData  <= '0;
            RXValid <= 1'b0;
            Overrun <= 1'b0;
`ifdef SPI_SHIFT_LOOPBACK_EN
            lb_q    <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            if (RXAck) begin
                RXValid <= 1'b0;
                Overrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (Start) begin
                        tx_q    <= (BitOrder == BIT_ORDER_MSB) ? (DataIN << (LEN_MAX - len_sel)) : DataIN;
                        rx_q    <= '0;
                        len_q   <= len_sel;
                        order_q <= BitOrder;
                        Busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef SPI_SHIFT_LOOPBACK_EN
                        lb_q    <= LoopBack;
`endif
                    end
                end
                SHIFT: begin
                    if (sample_en) begin
                        if (order_q == BIT_ORDER_MSB) begin
                            rx_q <= {rx_q[MaxWordLen-2:0], rx_in};
                        end else begin
                            rx_q <= (rx_q >> 1) | ({MaxWordLen{rx_in}} & (ONE_W << (len_q - LEN_ONE)));
                        end
                    end
                    if (shift_en) begin
                        tx_q <= (order_q == BIT_ORDER_MSB) ? (tx_q << 1) : (tx_q >> 1);
                    end
                    if (sample_en && at_last) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    // a coincident ack consumes the old word, so the new one never overruns
                    RXData  <= rx_q;
                    RXValid <= 1'b1;
                    Overrun <= RXAck ? 1'b0 : (Overrun || RXValid);
                    Busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - directed self-checking bench for spi_shift_engine
module tb_spi_shift_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [15:0] DataIN;
    logic [4:0]  WordLenSel;
    logic        BitOrder;
    logic        ShiftEdgeFlg;
    logic        SampleEdgeFlg;
    logic        MISO;
    logic        MOSI;
    logic        Busy;
    logic        Done;
    logic [15:0] RXData;
    logic        RXValid;
    logic        RXAck;
    logic        Overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spi_shift_engine #(
        .MaxWordLen(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .LoopBack      (1'b0),
`endif
        .Start         (Start),
        .DataIN        (DataIN),
        .WordLenSel    (WordLenSel),
        .BitOrder      (BitOrder),
        .ShiftEdgeFlg  (ShiftEdgeFlg),
        .SampleEdgeFlg (SampleEdgeFlg),
        .MISO          (MISO),
        .MOSI          (MOSI),
        .Busy          (Busy),
        .Done          (Done),
        .RXData        (RXData),
        .RXValid       (RXValid),
        .RXAck         (RXAck),
        .Overrun       (Overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample edge then launch edge per bit (or both together); ends one cycle after the DONE state.
    task automatic xfer(input logic [15:0] data, input logic [4:0] wsel, input logic order,
                        input int len, input logic [15:0] miso_w, input bit mirror,
                        input bit both, input bit poke, input bit ack_done,
                        output logic [15:0] mosi_w, output int dones);
        mosi_w     = '0;
        dones      = 0;
        DataIN     = data;
        WordLenSel = wsel;
        BitOrder   = order;
        Start      = 1'b1;
        tick();
        Start      = 1'b0;
        DataIN     = 16'hFFFF;
        WordLenSel = 5'd3;
        BitOrder   = ~order;
        check("busy_after_start", Busy, 1);
        for (int i = 0; i < len; i++) begin
            logic b;
            b = MOSI;
            if (order == 1'b0) mosi_w = {mosi_w[14:0], b};
            else               mosi_w[i] = b;
            MISO = mirror ? b : ((order == 1'b0) ? miso_w[len-1-i] : miso_w[i]);
            SampleEdgeFlg = 1'b1;
            ShiftEdgeFlg  = both;
            if (poke && i == 3) Start = 1'b1;
            tick();
            if (Done) dones++;
            SampleEdgeFlg = 1'b0;
            ShiftEdgeFlg  = 1'b0;
            Start         = 1'b0;
            if (!both && i != len - 1) begin
                ShiftEdgeFlg = 1'b1;
                tick();
                if (Done) dones++;
                ShiftEdgeFlg = 1'b0;
            end
        end
        if (poke)     Start = 1'b1;
        if (ack_done) RXAck = 1'b1;
        tick();
        Start = 1'b0;
        RXAck = 1'b0;
        if (Done) dones++;
    endtask

    task automatic ack();
        RXAck = 1'b1;
        tick();
        RXAck = 1'b0;
    endtask

    logic [15:0] mw;
    int          nd;

    initial begin
        rst = 1'b1; Start = 1'b0; DataIN = '0; WordLenSel = '0; BitOrder = 1'b0;
        ShiftEdgeFlg = 1'b0; SampleEdgeFlg = 1'b0; MISO = 1'b0; RXAck = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_mosi", MOSI, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_rxdata", RXData, 0);
        check("rst_rxvalid", RXValid, 0);
        check("rst_overrun", Overrun, 0);

        // MSB-first 8 bits
        xfer(16'h00A5, 5'd8, 1'b0, 8, 16'h003C, 0, 0, 0, 0, mw, nd);
        check("msb8_mosi", mw, 16'h00A5);
        check("msb8_dones", nd, 1);
        check("msb8_rxdata", RXData, 16'h003C);
        check("msb8_rxvalid", RXValid, 1);
        check("msb8_busy_end", Busy, 0);
        ack();
        check("msb8_ack_rxvalid", RXValid, 0);

        // LSB-first 12 bits, MISO mirrors MOSI
        xfer(16'h0ABC, 5'd12, 1'b1, 12, 16'h0000, 1, 0, 0, 0, mw, nd);
        check("lsb12_mosi", mw, 16'h0ABC);
        check("lsb12_rxdata", RXData, 16'h0ABC);
        check("lsb12_dones", nd, 1);
        ack();

        // WordLenSel clamping to 16
        xfer(16'h1234, 5'd0, 1'b0, 16, 16'hBEEF, 0, 0, 0, 0, mw, nd);
        check("len0_mosi", mw, 16'h1234);
        check("len0_rxdata", RXData, 16'hBEEF);
        check("len0_dones", nd, 1);
        ack();
        xfer(16'hC3A5, 5'd20, 1'b1, 16, 16'h0F0F, 0, 0, 0, 0, mw, nd);
        check("len20_mosi", mw, 16'hC3A5);
        check("len20_rxdata", RXData, 16'h0F0F);
        check("len20_dones", nd, 1);
        ack();
        check("len20_ack_rxvalid", RXValid, 0);

        // Overrun on second unread word
        xfer(16'h0009, 5'd4, 1'b0, 4, 16'h0006, 0, 0, 0, 0, mw, nd);
        check("ovr_first_rxdata", RXData, 16'h0006);
        check("ovr_first_overrun", Overrun, 0);
        xfer(16'h0005, 5'd4, 1'b0, 4, 16'h000A, 0, 0, 0, 0, mw, nd);
        check("ovr_second_rxdata", RXData, 16'h000A);
        check("ovr_second_rxvalid", RXValid, 1);
        check("ovr_second_overrun", Overrun, 1);
        ack();
        check("ovr_ack_rxvalid", RXValid, 0);
        check("ovr_ack_overrun", Overrun, 0);

        // Reset mid-transfer after 3 of 8 samples
        DataIN = 16'h00F0; WordLenSel = 5'd8; BitOrder = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            MISO = 1'b1; SampleEdgeFlg = 1'b1;
            tick();
            if (Done) nd++;
            SampleEdgeFlg = 1'b0; ShiftEdgeFlg = 1'b1;
            tick();
            if (Done) nd++;
            ShiftEdgeFlg = 1'b0;
        end
        check("abort_mosi_before_rst", MOSI, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_mosi", MOSI, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_rxvalid", RXValid, 0);
        check("abort_rxdata", RXData, 0);
        check("abort_overrun", Overrun, 0);
        for (int i = 0; i < 6; i++) begin
            SampleEdgeFlg = 1'b1; ShiftEdgeFlg = 1'b1;
            tick();
            if (Done || Busy) nd++;
        end
        SampleEdgeFlg = 1'b0; ShiftEdgeFlg = 1'b0;
        check("abort_no_done", nd, 0);
        xfer(16'h003C, 5'd8, 1'b0, 8, 16'h00C3, 0, 0, 0, 0, mw, nd);
        check("post_rst_mosi", mw, 16'h003C);
        check("post_rst_rxdata", RXData, 16'h00C3);
        check("post_rst_dones", nd, 1);
        ack();

        // Both edges per cycle, Start while busy and in DONE ignored
        xfer(16'h0096, 5'd8, 1'b0, 8, 16'h005A, 0, 1, 1, 0, mw, nd);
        check("both_mosi", mw, 16'h0096);
        check("both_rxdata", RXData, 16'h005A);
        check("both_dones", nd, 1);
        check("both_busy_after", Busy, 0);
        tick();
        check("both_no_restart", Busy, 0);

        // RXAck coincident with DONE: new word kept, no overrun
        xfer(16'h002D, 5'd6, 1'b1, 6, 16'h0013, 0, 0, 0, 1, mw, nd);
        check("ackdone_mosi", mw, 16'h002D);
        check("ackdone_rxdata", RXData, 16'h0013);
        check("ackdone_rxvalid", RXValid, 1);
        check("ackdone_overrun", Overrun, 0);
        ack();
        check("ackdone_final_rxvalid", RXValid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
